// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter sharing one UART_TX serializer among
//               NUM_REQ requesters, with busy tracking and inter-frame gap.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx_arbiter #(
    parameter  int DATA_WD      = 8,
    parameter  int NUM_REQ      = 4,
    parameter  int GAP_CYCLES   = 2,
    parameter  int BUSY_TIMEOUT = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*DATA_WD-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_par_en,
    input  logic [NUM_REQ-1:0]         i_req_par_typ,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [DATA_WD-1:0]         o_tx_p_data,
    output logic                       o_tx_data_valid,
    output logic                       o_tx_par_en,
    output logic                       o_tx_par_typ,
    input  logic                       i_tx_busy,
    output logic [ID_W-1:0]            o_grant_id,
    output logic                       o_active,
    output logic                       o_err_timeout
);

    localparam int C_MAX_CNT = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
    localparam int CNT_W     = (C_MAX_CNT < 1) ? 1 : $clog2(C_MAX_CNT + 1);

    localparam logic [CNT_W-1:0] C_BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ID_W-1:0]  C_ID_LAST   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_grant;
    logic [DATA_WD-1:0] r_data;
    logic               r_par_en;
    logic               r_par_typ;
    logic               r_err;

    logic               w_found;
    logic [ID_W-1:0]    w_winner;
    logic               w_accept;
    logic               w_timeout;
    logic [NUM_REQ-1:0] w_ready;

    // Search from the pointer upward, wrapping modulo NUM_REQ.
    always_comb begin : p_arb
        int              sum;
        logic [ID_W-1:0] idx;
        w_found  = 1'b0;
        w_winner = '0;
        sum      = 0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum = int'(r_ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = ID_W'(sum);
            if (!w_found && i_req_valid[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    // Gated by rst_n so no handshake can complete while reset is held.
    assign w_accept = (r_state == ST_IDLE) && i_enable && !i_tx_busy && w_found && rst_n;

    always_comb begin
        w_ready           = '0;
        w_ready[w_winner] = w_accept;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (i_tx_busy) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == C_BUSY_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                w_cnt_nxt = '0;
                if (!i_tx_busy) begin
                    w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_cnt == C_GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_timeout;
        end
    end

    // Frame parameters stay registered until the next accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= '0;
            r_grant   <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
        end else if (w_accept) begin
            r_ptr     <= (w_winner == C_ID_LAST) ? '0 : w_winner + 1'b1;
            r_grant   <= w_winner;
            r_data    <= i_req_data[w_winner*DATA_WD +: DATA_WD];
            r_par_en  <= i_req_par_en[w_winner];
            r_par_typ <= i_req_par_typ[w_winner];
        end
    end

    assign o_req_ready     = w_ready;
    assign o_tx_p_data     = r_data;
    assign o_tx_data_valid = (r_state == ST_LOAD);
    assign o_tx_par_en     = r_par_en;
    assign o_tx_par_typ    = r_par_typ;
    assign o_grant_id      = r_grant;
    assign o_active        = (r_state != ST_IDLE);
    assign o_err_timeout   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter with a stub UART_TX busy model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int  DATA_WD      = 8;
    localparam int  NUM_REQ      = 4;
    localparam int  GAP_CYCLES   = 2;
    localparam int  BUSY_TIMEOUT = 4;
    localparam int  FRAME        = 6;
    localparam int  DEPTH        = 16;
    localparam time HALF         = 5;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       enable = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ*DATA_WD-1:0] req_data = '0;
    logic [NUM_REQ-1:0]         req_par_en = '0;
    logic [NUM_REQ-1:0]         req_par_typ = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [DATA_WD-1:0]         tx_p_data;
    logic                       tx_data_valid;
    logic                       tx_par_en;
    logic                       tx_par_typ;
    logic                       tx_busy = 1'b0;
    logic [1:0]                 grant_id;
    logic                       active;
    logic                       err_timeout;

    uart_tx_arbiter #(
        .DATA_WD      (DATA_WD),
        .NUM_REQ      (NUM_REQ),
        .GAP_CYCLES   (GAP_CYCLES),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_enable        (enable),
        .i_req_valid     (req_valid),
        .i_req_data      (req_data),
        .i_req_par_en    (req_par_en),
        .i_req_par_typ   (req_par_typ),
        .o_req_ready     (req_ready),
        .o_tx_p_data     (tx_p_data),
        .o_tx_data_valid (tx_data_valid),
        .o_tx_par_en     (tx_par_en),
        .o_tx_par_typ    (tx_par_typ),
        .i_tx_busy       (tx_busy),
        .o_grant_id      (grant_id),
        .o_active        (active),
        .o_err_timeout   (err_timeout)
    );

    always #HALF clk = ~clk;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       pen;
        logic       ptyp;
    } exp_t;

    exp_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Settings written by the main sequence at posedge, applied by the driver at negedge.
    logic               want_enable = 1'b0;
    logic               force_busy  = 1'b0;
    logic               stub_mode   = 1'b0;
    logic               check_gap   = 1'b0;
    logic [NUM_REQ-1:0] cfg_pen     = '0;
    logic [NUM_REQ-1:0] cfg_ptyp    = '0;
    logic [7:0]         rq_mem [NUM_REQ][DEPTH];
    int                 rq_wr  [NUM_REQ];
    int                 rq_rd  [NUM_REQ];

    // Observations owned by the driver/monitor loop.
    int                 cyc       = 0;
    int                 busy_cnt  = 0;
    int                 fall_cyc  = 0;
    int                 last_dv   = 0;
    int                 dv_cnt    = 0;
    int                 err_cnt   = 0;
    int                 ready_cyc [NUM_REQ];
    logic               gap_armed = 1'b0;
    logic               prev_err  = 1'b0;
    logic               prev_busy;
    logic [NUM_REQ-1:0] acc       = '0;
    exp_t               e;

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            rq_wr[i]     = 0;
            rq_rd[i]     = 0;
            ready_cyc[i] = 0;
        end
    end

    task automatic load(input int id, input logic [7:0] b);
        rq_mem[id][rq_wr[id]] = b;
        rq_wr[id]++;
        sb.push_back('{id: 2'(id), data: b, pen: cfg_pen[id], ptyp: cfg_ptyp[id]});
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            // UART_TX stand-in: Busy rises after DATA_VALID and lasts FRAME clocks.
            if (!rst_n) begin
                busy_cnt = 0;
            end else if (tx_data_valid && !stub_mode) begin
                busy_cnt = FRAME;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            prev_busy = tx_busy;
            tx_busy   = force_busy | (busy_cnt > 0);
            if (prev_busy && !tx_busy) fall_cyc = cyc;

            if (tx_data_valid) begin
                dv_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_dv", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("grant_id", grant_id, e.id);
                    chk("p_data", tx_p_data, e.data);
                    chk("par_en", tx_par_en, e.pen);
                    chk("par_typ", tx_par_typ, e.ptyp);
                end
                if (check_gap && gap_armed) begin
                    chk("gap_busy_fall_to_dv", cyc - fall_cyc, GAP_CYCLES + 2);
                end
                gap_armed = check_gap;
                last_dv   = cyc;
            end
            if (!check_gap) gap_armed = 1'b0;

            if (err_timeout) begin
                err_cnt++;
                chk("err_delay", cyc - last_dv, BUSY_TIMEOUT + 1);
                chk("err_active", active, 0);
                chk("err_width", prev_err, 0);
            end
            prev_err = err_timeout;

            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i]) rq_rd[i]++;
            end
            enable      = want_enable;
            req_par_en  = cfg_pen;
            req_par_typ = cfg_ptyp;
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i] = (rq_rd[i] < rq_wr[i]);
                if (req_valid[i]) req_data[i*DATA_WD +: DATA_WD] = rq_mem[i][rq_rd[i]];
            end
            #1;
            acc = req_ready & req_valid;
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 1);
                chk("ready_has_valid", 32'(|(req_ready & req_valid)), 1);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) ready_cyc[i]++;
            end
        end
    end

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, req_ready, 0);
        chk({tag, "_rst_p_data"}, tx_p_data, 0);
        chk({tag, "_rst_dv"}, tx_data_valid, 0);
        chk({tag, "_rst_par_en"}, tx_par_en, 0);
        chk({tag, "_rst_par_typ"}, tx_par_typ, 0);
        chk({tag, "_rst_grant"}, grant_id, 0);
        chk({tag, "_rst_active"}, active, 0);
        chk({tag, "_rst_err"}, err_timeout, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while ((sb.size() != 0 || active || tx_busy) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_completes"}, 32'(n < budget), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_dv(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (dv_cnt < target && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_dv_seen"}, 32'(dv_cnt >= target), 1);
    endtask

    initial begin
        #(HALF * 200000);
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        want_enable = 1'b1;
        do_reset("init");

        // 1: single requester, no parity
        dv_cnt = 0;
        ready_cyc[0] = 0;
        cfg_pen  = 4'b0000;
        cfg_ptyp = 4'b0000;
        load(0, 8'hA3);
        wait_idle("t1", 60);
        chk("t1_ready_cycles", ready_cyc[0], 1);
        chk("t1_dv_count", dv_cnt, 1);

        // 2: all valid from pointer 0 -> strict rotation, odd parity on 1 and 3
        do_reset("t2");
        dv_cnt   = 0;
        cfg_pen  = 4'b1111;
        cfg_ptyp = 4'b1010;
        load(0, 8'h10);
        load(1, 8'h21);
        load(2, 8'h32);
        load(3, 8'h43);
        wait_idle("t2", 200);
        chk("t2_dv_count", dv_cnt, 4);

        // 3: one requester streaming three bytes, gap enforced between frames
        dv_cnt    = 0;
        cfg_pen   = 4'b0100;
        cfg_ptyp  = 4'b0000;
        check_gap = 1'b1;
        load(2, 8'hB4);
        load(2, 8'hB5);
        load(2, 8'hB6);
        wait_idle("t3", 200);
        check_gap = 1'b0;
        chk("t3_dv_count", dv_cnt, 3);

        // 4: Busy never rises -> timeout pulse, byte dropped
        stub_mode = 1'b1;
        err_cnt   = 0;
        dv_cnt    = 0;
        cfg_pen   = 4'b0000;
        load(1, 8'hD2);
        wait_idle("t4", 60);
        chk("t4_err_count", err_cnt, 1);
        chk("t4_dv_count", dv_cnt, 1);
        stub_mode = 1'b0;

        // 7: external Busy in IDLE blocks grants
        force_busy = 1'b1;
        repeat (2) @(posedge clk);
        d0 = dv_cnt;
        load(3, 8'h77);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_block_dv", dv_cnt, d0);
        chk("busy_block_active", active, 0);
        force_busy = 1'b0;
        wait_idle("t7", 60);
        chk("busy_release_dv", dv_cnt, d0 + 1);

        // 5: async reset mid-frame; pointer back to 0 so req0 beats req3
        d0 = dv_cnt;
        load(1, 8'h5A);
        wait_dv("t5", d0 + 1, 40);
        repeat (3) @(posedge clk);
        do_reset("t5");
        load(0, 8'h11);
        load(3, 8'h33);
        wait_idle("t5b", 200);

        // 6: ENABLE low mid-frame holds off the pending requester
        d0 = dv_cnt;
        load(0, 8'h66);
        wait_dv("t6", d0 + 1, 40);
        want_enable = 1'b0;
        load(1, 8'h67);
        repeat (FRAME + GAP_CYCLES + 8) @(posedge clk);
        #1;
        chk("t6_hold_dv", dv_cnt, d0 + 1);
        chk("t6_hold_pending", sb.size(), 1);
        chk("t6_hold_active", active, 0);
        @(posedge clk);
        #1;
        want_enable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_resume_dv", dv_cnt, d0 + 2);
        wait_idle("t6b", 60);

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
